// File: rtl/fetch_module.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem reads under a
// credit limit, and buffers returned words for decode, with taken-branch redirect.
module fetch_module #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [17:0] brbus,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [15:0]   fetch_pc;
  logic [15:0]   resp_pc;
  logic [15:0]   buf_pc   [DEPTH];
  logic [15:0]   buf_word [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] outst_nxt;
  logic [15:0]   target;
  logic          pop;
  logic          flush;
  logic          acc;
  logic          push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  assign pop       = (count != '0) & brbus[17];
  assign flush     = pop & brbus[16];
  assign acc       = imem_req & imem_gnt;
  assign push      = imem_rvalid & (drop == '0) & ~flush;
  assign target    = buf_pc[rd_ptr] + 16'd1 + brbus[15:0];
  assign imem_addr = fetch_pc;

  // Credit counts buffered plus in-flight words so every response has a slot.
  assign imem_req = resetn & (({1'b0, count} + {1'b0, outst}) < DEPTH_W) & ~flush;

  assign inst    = (count != '0) ? buf_word[rd_ptr] : 16'h0000;
  assign inst_pc = (count != '0) ? buf_pc[rd_ptr]   : 16'h0000;

  always_comb begin
    outst_nxt = outst + CW'(acc) - CW'(imem_rvalid);
    count_nxt = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      outst    <= '0;
      drop     <= '0;
    end else begin
      outst <= outst_nxt;
      if (flush) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc <= target;
        resp_pc  <= target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop     <= outst_nxt;
      end else begin
        if (acc) fetch_pc <= fetch_pc + 16'd1;
        if (imem_rvalid && (drop != '0)) drop <= drop - CW'(1);
        if (push) begin
          wr_ptr  <= ptr_inc(wr_ptr);
          resp_pc <= resp_pc + 16'd1;
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        count <= count_nxt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      buf_pc[wr_ptr]   <= resp_pc;
      buf_word[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_module.sv
// Directed bench for fetch_module: an in-order memory model plus a golden PC/address
// model checked every cycle, with stall, branch, wrap, random-delay and reset cases.
module tb_fetch_module;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [17:0] brbus = '0;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;

  fetch_module #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .brbus       (brbus),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          cyc = 0;
  int          last_due = -1;
  int          nvec = 0;
  int          nfail = 0;
  int          fixed_lat = 1;
  bit          rnd = 1'b0;
  logic [15:0] exp_pc = 16'h0000;
  logic [15:0] exp_addr = 16'h0000;

  // Memory contents are never zero in the ranges used, so inst==0 means empty.
  function automatic logic [15:0] memw(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: memory response, grant and brbus are driven at the negedge,
  // outputs are checked 1 time unit later. With en set, br is applied only when
  // the head pc equals at_pc; otherwise decode simply accepts the head.
  task automatic step(input logic [17:0] br, input bit en, input logic [15:0] at_pc,
                      output bit hit);
    logic [17:0] b;
    logic [15:0] tgt;
    bit          hv;
    bit          popping;
    bit          flushing;
    int          due;
    pend_t       e;
    @(negedge clock);
    hv  = (inst != 16'h0000);
    hit = hv && (inst_pc == at_pc);
    b   = (!en || hit) ? br : 18'h20000;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      e = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = memw(e.addr);
    end
    imem_gnt = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    brbus    = b;
    #1;
    if (hv) begin
      check("inst_pc", {16'h0, inst_pc}, {16'h0, exp_pc});
      check("inst", {16'h0, inst}, {16'h0, memw(inst_pc)});
    end
    popping  = hv && b[17];
    flushing = popping && b[16];
    tgt      = inst_pc + 16'd1 + b[15:0];
    if (flushing) check("req_in_flush", {31'h0, imem_req}, 32'h0);
    if (imem_req && imem_gnt) begin
      check("imem_addr", {16'h0, imem_addr}, {16'h0, exp_addr});
      exp_addr = exp_addr + 16'd1;
      due = cyc + (rnd ? 1 + $urandom_range(0, 4) : fixed_lat);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      e.addr = imem_addr;
      e.due  = due;
      pend.push_back(e);
    end
    check("outstanding_le_2", {31'h0, pend.size() <= 2}, 32'h1);
    if (popping) exp_pc = flushing ? tgt : exp_pc + 16'd1;
    if (flushing) exp_addr = tgt;
    cyc++;
  endtask

  task automatic run_to(input logic [17:0] br, input logic [15:0] pc, input int budget);
    bit h;
    int n;
    h = 1'b0;
    n = 0;
    while (!h && n < budget) begin
      step(br, 1'b1, pc, h);
      n++;
    end
    check($sformatf("reach_pc_%h", pc), {31'h0, h}, 32'h1);
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    brbus       = 18'h20000;
    repeat (2) @(negedge clock);
    check("rst_inst", {16'h0, inst}, 32'h0);
    check("rst_inst_pc", {16'h0, inst_pc}, 32'h0);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    pend.delete();
    last_due = cyc;
    exp_pc   = 16'h0000;
    exp_addr = 16'h0000;
    resetn   = 1'b1;
  endtask

  initial begin
    bit h;
    logic [17:0] br;

    // Zero-wait fill: first word visible two cycles after the first request.
    do_reset();
    step(18'h20000, 1'b0, 16'h0, h);
    check("fill_c0_req", {31'h0, imem_req}, 32'h1);
    check("fill_c0_empty", {16'h0, inst}, 32'h0);
    step(18'h20000, 1'b0, 16'h0, h);
    check("fill_c1_empty", {16'h0, inst}, 32'h0);
    step(18'h20000, 1'b0, 16'h0, h);
    check("fill_c2_inst", {16'h0, inst}, {16'h0, memw(16'h0000)});

    // Hazard stall for 3 cycles at pc 5, then release.
    run_to(18'h00000, 16'h0005, 40);
    for (int i = 0; i < 2; i++) begin
      step(18'h00000, 1'b1, 16'h0005, h);
      check("stall_hold", {31'h0, h}, 32'h1);
    end
    check("stall_req_off", {31'h0, imem_req}, 32'h0);
    run_to(18'h20000, 16'h0006, 10);
    run_to(18'h20000, 16'h0008, 20);

    // Taken branch at pc 4, offset 3 -> target 8.
    do_reset();
    run_to(18'h30003, 16'h0004, 40);
    run_to(18'h20000, 16'h0008, 20);
    run_to(18'h20000, 16'h000A, 20);

    // Backward branch to 0, then branch to FFFF to exercise the wrap.
    do_reset();
    run_to(18'h3FFFD, 16'h0002, 40);
    run_to(18'h3FFFE, 16'h0000, 20);
    run_to(18'h20000, 16'hFFFF, 20);
    run_to(18'h20000, 16'h0000, 20);
    run_to(18'h20000, 16'h0003, 20);

    // Slow memory so branches find stale words still in flight.
    do_reset();
    fixed_lat = 3;
    run_to(18'h30010, 16'h0001, 40);
    run_to(18'h20000, 16'h0014, 40);
    fixed_lat = 1;

    // Random grant/latency with random stalls and occasional short branches.
    do_reset();
    rnd = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      br = {($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), 16'($urandom_range(0, 15))};
      step(br, 1'b0, 16'h0, h);
    end
    rnd = 1'b0;

    // Reset asserted in the middle of a flush cycle.
    do_reset();
    fixed_lat = 2;
    run_to(18'h30005, 16'h0003, 40);
    resetn = 1'b0;
    #1;
    check("midrst_inst", {16'h0, inst}, 32'h0);
    check("midrst_inst_pc", {16'h0, inst_pc}, 32'h0);
    check("midrst_req", {31'h0, imem_req}, 32'h0);
    fixed_lat = 1;
    do_reset();
    step(18'h20000, 1'b0, 16'h0, h);
    check("post_rst_req", {31'h0, imem_req}, 32'h1);
    check("post_rst_addr", {16'h0, imem_addr}, 32'h0);
    run_to(18'h20000, 16'h0004, 30);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
